// File: rtl/par_frame_checker.sv
// par_frame_checker: serial frame receiver with run-time odd/even parity check.
// A frame is DATA_W data bits followed by one parity bit, each carried on a
// bit_valid beat. The first data bit is flagged by sof. Completion produces a
// registered data word, a parity-error flag, a one-cycle frame_done pulse and
// a saturating count of frames that failed parity.
//
// Handshake: there is no back-pressure. A beat is any cycle with bit_valid=1,
// and the block consumes every beat on the rising clk edge it is sampled.
// Outputs data_out/pec/err_cnt change only on frame completion (or reset) and
// frame_done is high for the single cycle after the parity beat.
module par_frame_checker #(
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              odd,
    input  logic              sof,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              pec,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    // Wide enough to hold the value DATA_W (bits received so far).
    localparam int BCNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic                par_q, par_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                pec_q, pec_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic                pec_now;

    // Place a new bit so that after DATA_W shifts the first bit received sits
    // at the MSB (MSB_FIRST=1) or at the LSB (MSB_FIRST=0).
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                   input logic              b);
        logic [DATA_W-1:0] r;
        if (MSB_FIRST != 0) begin
            r    = cur << 1;
            r[0] = b;
        end else begin
            r            = cur >> 1;
            r[DATA_W-1]  = b;
        end
        return r;
    endfunction

    // Next-state and datapath update; a sof beat restarts from any state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        mode_d  = mode_q;
        data_d  = data_q;
        pec_d   = pec_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pec_now = par_q ^ bit_in ^ mode_q;

        if (bit_valid && sof) begin
            // Start of frame; a frame in progress is dropped without reporting.
            shift_d = shift_in('0, bit_in);
            cnt_d   = BCNT_W'(1);
            par_d   = bit_in;
            mode_d  = odd;
            state_d = (DATA_W == 1) ? PAR : DATA;
        end else if (bit_valid) begin
            case (state_q)
                DATA: begin
                    shift_d = shift_in(shift_q, bit_in);
                    par_d   = par_q ^ bit_in;
                    cnt_d   = cnt_q + BCNT_W'(1);
                    if (cnt_q == BCNT_W'(DATA_W - 1)) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    state_d = IDLE;
                    data_d  = shift_q;
                    pec_d   = pec_now;
                    done_d  = 1'b1;
                    if (pec_now && !(&err_q)) begin
                        err_d = err_q + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE: beats without sof carry no frame and are ignored.
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            pec_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            pec_q   <= pec_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out   = data_q;
    assign frame_done = done_q;
    assign pec        = pec_q;
    assign err_cnt    = err_q;
    // Derived from the state register, so it is itself registered.
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_par_frame_checker.sv
// tb_par_frame_checker: drives one shared serial stream into three checker
// instances with different parameters and compares each against a frame-level
// reference model (collect bits, count ones, place bits by index).
module tb_par_frame_checker;

    localparam int NDUT = 3;
    localparam int DW[NDUT] = '{4, 4, 1};
    localparam int CW[NDUT] = '{2, 8, 8};
    localparam int MF[NDUT] = '{1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic odd = 1'b0;
    logic sof = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;

    logic [3:0] d0_data;
    logic       d0_fd, d0_pec, d0_busy;
    logic [1:0] d0_cnt;
    logic [3:0] d1_data;
    logic       d1_fd, d1_pec, d1_busy;
    logic [7:0] d1_cnt;
    logic [0:0] d2_data;
    logic       d2_fd, d2_pec, d2_busy;
    logic [7:0] d2_cnt;

    par_frame_checker #(.DATA_W(4), .CNT_W(2), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .odd(odd), .sof(sof), .bit_valid(bit_valid),
        .bit_in(bit_in), .data_out(d0_data), .frame_done(d0_fd), .pec(d0_pec),
        .err_cnt(d0_cnt), .busy(d0_busy));

    par_frame_checker #(.DATA_W(4), .CNT_W(8), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .odd(odd), .sof(sof), .bit_valid(bit_valid),
        .bit_in(bit_in), .data_out(d1_data), .frame_done(d1_fd), .pec(d1_pec),
        .err_cnt(d1_cnt), .busy(d1_busy));

    par_frame_checker #(.DATA_W(1), .CNT_W(8), .MSB_FIRST(1)) dut2 (
        .clk(clk), .rst(rst), .odd(odd), .sof(sof), .bit_valid(bit_valid),
        .bit_in(bit_in), .data_out(d2_data), .frame_done(d2_fd), .pec(d2_pec),
        .err_cnt(d2_cnt), .busy(d2_busy));

    // Uniform views of the three instances for the monitor.
    logic [7:0] a_data[NDUT];
    logic [7:0] a_cnt[NDUT];
    logic       a_fd[NDUT], a_pec[NDUT], a_busy[NDUT];
    assign a_data[0] = {4'b0, d0_data};
    assign a_data[1] = {4'b0, d1_data};
    assign a_data[2] = {7'b0, d2_data};
    assign a_cnt[0]  = {6'b0, d0_cnt};
    assign a_cnt[1]  = d1_cnt;
    assign a_cnt[2]  = d2_cnt;
    assign a_fd[0] = d0_fd;   assign a_fd[1] = d1_fd;   assign a_fd[2] = d2_fd;
    assign a_pec[0] = d0_pec; assign a_pec[1] = d1_pec; assign a_pec[2] = d2_pec;
    assign a_busy[0] = d0_busy; assign a_busy[1] = d1_busy; assign a_busy[2] = d2_busy;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    // Expected completion record: {data[7:0], pec, err_cnt[7:0]}.
    logic [16:0] exp_q[NDUT][$];

    // Reference model: per-instance frame collection.
    bit         m_active[NDUT];
    int         m_n[NDUT];
    bit         m_bits[NDUT][8];
    bit         m_mode[NDUT];
    int         m_cnt[NDUT];
    logic [7:0] h_data[NDUT];
    bit         h_pec[NDUT];
    bit         e_fd[NDUT];
    bit         e_busy[NDUT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies each sampled beat with frame-level rules.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) e_fd[k] = 1'b0;
        if (rst) begin
            for (int k = 0; k < NDUT; k++) begin
                m_active[k] = 1'b0;
                m_n[k]      = 0;
                m_cnt[k]    = 0;
                h_data[k]   = 8'h0;
                h_pec[k]    = 1'b0;
            end
        end else if (bit_valid) begin
            for (int k = 0; k < NDUT; k++) begin
                if (sof) begin
                    m_active[k]  = 1'b1;
                    m_bits[k][0] = bit_in;
                    m_n[k]       = 1;
                    m_mode[k]    = odd;
                end else if (m_active[k]) begin
                    if (m_n[k] < DW[k]) begin
                        m_bits[k][m_n[k]] = bit_in;
                        m_n[k]++;
                    end else begin
                        int         ones;
                        logic [7:0] d;
                        bit         p;
                        ones = int'(bit_in);
                        d = 8'h0;
                        for (int i = 0; i < DW[k]; i++) begin
                            ones += int'(m_bits[k][i]);
                            d[(MF[k] != 0) ? (DW[k] - 1 - i) : i] = m_bits[k][i];
                        end
                        p = ((ones % 2) == 1) ^ m_mode[k];
                        if (p && (m_cnt[k] < (1 << CW[k]) - 1)) m_cnt[k]++;
                        h_data[k] = d;
                        h_pec[k]  = p;
                        e_fd[k]   = 1'b1;
                        m_active[k] = 1'b0;
                        exp_q[k].push_back({d, p, 8'(m_cnt[k])});
                    end
                end
            end
        end
        for (int k = 0; k < NDUT; k++) e_busy[k] = m_active[k];
    end

    // Monitor: every cycle check held outputs; pop and compare on frame_done.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("busy[%0d]", k), 32'(a_busy[k]), 32'(e_busy[k]));
                chk($sformatf("frame_done[%0d]", k), 32'(a_fd[k]), 32'(e_fd[k]));
                chk($sformatf("data_out[%0d]", k), 32'(a_data[k]), 32'(h_data[k]));
                chk($sformatf("pec[%0d]", k), 32'(a_pec[k]), 32'(h_pec[k]));
                chk($sformatf("err_cnt[%0d]", k), 32'(a_cnt[k]), 32'(m_cnt[k]));
                if (a_fd[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_frame[%0d]", k), 32'd1, 32'd0);
                    end else begin
                        logic [16:0] e;
                        e = exp_q[k].pop_front();
                        chk($sformatf("frame_rec[%0d]", k),
                            32'({a_data[k], a_pec[k], a_cnt[k]}), 32'(e));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_valid = 1'b0;
        sof = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic beat(input bit s, input bit o, input bit b);
        sof = s;
        odd = o;
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        sof = 1'b0;
        odd = 1'($urandom_range(0, 1));
    endtask

    // bits[3] is sent first; o_mid is driven on the non-sof beats.
    task automatic frame(input logic [3:0] bits, input bit p, input bit o_sof,
                         input bit o_mid, input int stall);
        logic [3:0] b;
        b = bits;
        beat(1'b1, o_sof, b[3]);
        gap(stall);
        for (int i = 2; i >= 0; i--) begin
            beat(1'b0, o_mid, b[i]);
            gap(stall);
        end
        beat(1'b0, o_mid, p);
    endtask

    int exp_sat[5] = '{1, 2, 3, 3, 3};

    // ---------------- stimulus ----------------
    initial begin
        gap(1);
        do_reset();
        do_reset();
        chk("reset_data", 32'(d0_data), 32'h0);
        chk("reset_cnt", 32'(d0_cnt), 32'h0);
        chk("reset_busy", 32'(d0_busy), 32'h0);
        mon_en = 1'b1;

        // Even frame 1,0,1,1 parity 1.
        frame(4'b1011, 1'b1, 1'b0, 1'b0, 0);
        chk("even_data", 32'(d0_data), 32'hB);
        chk("even_pec", 32'(d0_pec), 32'h0);
        chk("even_done", 32'(d0_fd), 32'h1);
        chk("even_cnt", 32'(d0_cnt), 32'h0);
        chk("lsb_first_data", 32'(d1_data), 32'hD);
        gap(2);

        // Odd mode at sof; mode change during data has no effect.
        frame(4'b1011, 1'b1, 1'b1, 1'b1, 0);
        chk("odd_pec", 32'(d0_pec), 32'h1);
        chk("odd_cnt", 32'(d0_cnt), 32'h1);
        frame(4'b1011, 1'b1, 1'b1, 1'b0, 0);
        chk("odd_mid_pec", 32'(d0_pec), 32'h1);
        chk("odd_mid_cnt", 32'(d0_cnt), 32'h2);
        gap(1);

        // Stalls between every bit.
        frame(4'b0110, 1'b0, 1'b0, 1'b0, 3);
        chk("stall_data", 32'(d0_data), 32'h6);
        chk("stall_pec", 32'(d0_pec), 32'h0);
        gap(2);

        // Abort: sof on the third beat restarts the frame.
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);
        chk("abort_data", 32'(d0_data), 32'hF);
        chk("abort_pec", 32'(d0_pec), 32'h0);
        chk("abort_cnt", 32'(d0_cnt), 32'h2);

        // Back-to-back frames; second one checks LSB-first placement.
        frame(4'b1000, 1'b1, 1'b0, 1'b0, 0);
        frame(4'b1000, 1'b1, 1'b0, 1'b0, 0);
        chk("lsb_1000_data", 32'(d1_data), 32'h1);
        chk("lsb_1000_pec", 32'(d1_pec), 32'h0);
        gap(1);

        // Saturation of the 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            frame(4'b0011, 1'b0, 1'b1, 1'b1, 0);
            chk($sformatf("sat_cnt_%0d", i), 32'(d0_cnt), 32'(exp_sat[i]));
            gap(1);
        end

        // Reset in the middle of a frame.
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        do_reset();
        chk("midrst_data", 32'(d0_data), 32'h0);
        chk("midrst_cnt", 32'(d0_cnt), 32'h0);
        chk("midrst_busy", 32'(d0_busy), 32'h0);
        frame(4'b0101, 1'b0, 1'b0, 1'b0, 0);
        chk("post_rst_data", 32'(d0_data), 32'h5);
        chk("post_rst_pec", 32'(d0_pec), 32'h0);

        // Randomized traffic.
        for (int it = 0; it < 500; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else if (r < 25) begin
                gap(1);
            end else if (r < 40) begin
                frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)));
            end else begin
                beat(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end
        end

        gap(3);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("queue_empty[%0d]", k), 32'(exp_q[k].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
